// File: rtl/uart_rx_path.sv
// uart_rx_path: receive half of the UART.
//   Oversamples the rx line with the shared 16x baud tick, recovers frames
//   of DBIT data bits sent LSB first, checks the stop bit, and buffers good
//   bytes in a 2**FIFO_W entry first-word-fall-through FIFO.
// Ports:
//   clk        system clock
//   reset      asynchronous reset, active-low
//   s_tick     baud oversample strobe (16 per bit), one clk wide
//   rx         asynchronous serial input, idles high
//   rd_uart    pop strobe for the FIFO head
//   clr_err    clears the sticky error flags
//   r_data     FIFO head, valid while rx_empty=0
//   rx_empty   FIFO empty
//   rx_full    FIFO full
//   frame_err  sticky: a frame arrived with stop bit = 0
//   overrun    sticky: a good frame was dropped because the FIFO was full
module uart_rx_path #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rd_uart,
  input  logic            clr_err,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            frame_err,
  output logic            overrun
);

  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Tick counter must also reach SB_TICK-1 for 1.5/2 stop bits.
  localparam int S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int DEPTH = 2 ** FIFO_W;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [1:0]        sync_q, sync_d;
  logic              rx_s;
  logic              done;

  logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              last_wr_q, last_wr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic [DBIT-1:0]   mem_q [DEPTH];

  logic              wr_req, wr_en, rd_en, ptr_eq;

  assign sync_d = {sync_q[0], rx};
  assign rx_s   = sync_q[1];

  // Receiver FSM: only IDLE exit ignores s_tick.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_W'(7)) begin
            // Mid start bit: a line back high here was only a glitch.
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_W'(15)) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_W'(DBIT - 1)) state_d = STOP;
            else                       n_d     = n_q + N_W'(1);
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO control. A write while full is still accepted if the head is
  // popped in the same cycle; a pop while empty is ignored.
  assign ptr_eq   = (wr_ptr_q == rd_ptr_q);
  assign rx_empty = ptr_eq & ~last_wr_q;
  assign rx_full  = ptr_eq &  last_wr_q;
  assign wr_req   = done & rx_s;
  assign wr_en    = wr_req & (~rx_full | rd_uart);
  assign rd_en    = rd_uart & ~rx_empty;

  always_comb begin
    wr_ptr_d  = wr_en ? wr_ptr_q + FIFO_W'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + FIFO_W'(1) : rd_ptr_q;
    // Equal pointers mean full if the last pointer move was a write.
    last_wr_d = last_wr_q;
    if (wr_en && !rd_en)      last_wr_d = 1'b1;
    else if (rd_en && !wr_en) last_wr_d = 1'b0;
    // Clear first so a same-cycle error event keeps the flag set.
    ferr_d = clr_err ? 1'b0 : ferr_q;
    ovr_d  = clr_err ? 1'b0 : ovr_q;
    if (done && !rx_s)                 ferr_d = 1'b1;
    if (wr_req && rx_full && !rd_uart) ovr_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      sync_q    <= 2'b11;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      last_wr_q <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      sync_q    <= sync_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      last_wr_q <= last_wr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Storage entries, each cleared by reset so r_data reads 0 afterwards.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          mem_q[gi] <= '0;
        else if (wr_en && (wr_ptr_q == FIFO_W'(gi)))
          mem_q[gi] <= b_q;
      end
    end
  endgenerate

  assign r_data    = mem_q[rd_ptr_q];
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
